// File: rtl/fib_seq_pkg.sv
// Shared state encoding, default sizes and helpers for the Fibonacci term buffer.
package fib_seq_pkg;

    localparam int unsigned DefaultDataW = 32;
    localparam int unsigned DefaultDepth = 64;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StGen  = 2'd1;
    localparam state_t StDone = 2'd2;

    // Requested term count limited to the buffer depth.
    function automatic int unsigned clamp_n(input int unsigned n, input int unsigned depth);
        return (n > depth) ? depth : n;
    endfunction

endpackage

// File: rtl/fib_seq_ram.sv
// Term storage: one synchronous write port and one registered read port.
module fib_seq_ram
    import fib_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fib_seq_buffer.sv
// Fibonacci term generator with an integrated buffer and a checked read port.
// Optional build macro FIB_SEQ_CHECKSUM_EN adds checksum_o, the per-run sum of stored terms.
module fib_seq_buffer
    import fib_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned DEPTH  = DefaultDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   n_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
`ifdef FIB_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum_o,
`endif
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_err_o
);

    localparam int unsigned CntW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   n_eff_q, n_eff_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] a_q, a_d;
    // b carries one extra bit; a set MSB marks the next term as unrepresentable.
    logic [DATA_W:0]   b_q, b_d;
    logic [DATA_W:0]   sum;
    logic              start_ok;
    logic              we;
    logic              rd_valid_q;
    logic              rd_err_q;
    logic [DATA_W-1:0] ram_rdata;

    assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
    assign we       = (state_q == StGen) && (idx_q < n_eff_q);
    assign sum      = {1'b0, a_q} + {1'b0, b_q[DATA_W-1:0]};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_eff_d    = n_eff_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        a_d        = a_q;
        b_d        = b_q;
        if (start_ok) begin
            state_d    = StGen;
            n_eff_d    = CntW'(clamp_n(32'(n_i), DEPTH));
            idx_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            a_d        = '0;
            b_d        = (DATA_W + 1)'(1);
        end else if (state_q == StGen) begin
            if (we) begin
                idx_d   = idx_q + 1'b1;
                count_d = idx_q + 1'b1;
                a_d     = b_q[DATA_W-1:0];
                b_d     = sum;
                if (idx_d == n_eff_q) begin
                    state_d = StDone;
                end else if (b_q[DATA_W]) begin
                    // The following term does not fit, so this write is the last one.
                    overflow_d = 1'b1;
                    state_d    = StDone;
                end
            end else begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            n_eff_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_eff_q    <= n_eff_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_valid_q <= rd_req_i;
            // The address written this cycle is not yet counted, so it reads as an error.
            rd_err_q   <= rd_req_i && ({1'b0, rd_addr_i} >= count_q);
        end
    end

    fib_seq_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (we),
        .waddr_i (idx_q[ADDR_W-1:0]),
        .wdata_i (a_q),
        .re_i    (rd_req_i),
        .raddr_i (rd_addr_i),
        .rdata_o (ram_rdata)
    );

`ifdef FIB_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_ok) begin
            checksum_d = '0;
        end else if (we) begin
            checksum_d = checksum_q + a_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign busy_o     = (state_q == StGen);
    assign done_o     = (state_q == StDone);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_data_o  = (rd_valid_q && !rd_err_q) ? ram_rdata : '0;

endmodule

// File: doc/fib_seq_buffer.md
Name: fib_seq_buffer

Overview:
Parametrised Fibonacci sequence engine with an integrated term buffer. On a start pulse it generates F(0)..F(n-1), one term per clock, and stores each term at buffer address i. A registered random-access read port serves stored terms with one-cycle latency and flags out-of-range reads. It replaces the fixed 32-bit/64-entry generator-plus-memory pairing and adds overflow detection, run control and a read handshake.

Parameters:
DATA_W, 32, width of each term and of the buffer word
DEPTH, 64, number of buffer entries; maximum terms per run
ADDR_W, $clog2(DEPTH), buffer address width (derived; do not override)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  run request pulse; sampled only in IDLE or DONE
n  in  ADDR_W+1  requested term count, sampled with start
busy  out  1  high while in GEN
done  out  1  high in DONE until next start or rst
count  out  ADDR_W+1  number of valid terms currently in buffer
overflow  out  1  sticky: the run stopped early on DATA_W overflow
rd_req  in  1  read request, accepted in any state
rd_addr  in  ADDR_W  read address
rd_valid  out  1  pulses one cycle after each rd_req
rd_data  out  DATA_W  read data, valid with rd_valid
rd_err  out  1  with rd_valid: rd_addr >= count at request time

Behaviour:
- Reset: state IDLE; busy=0, done=0, count=0, overflow=0, rd_valid=0, rd_data=0, rd_err=0. Buffer contents are not cleared; count=0 makes them unreadable.
- FSM IDLE -> GEN on start. GEN -> DONE after the last term or on overflow. DONE -> GEN on start. Any state -> IDLE on rst.
- On the start cycle: n_eff = min(n, DEPTH); count, overflow and the internal index are cleared; operands a=0, b=1.
- GEN, one term per cycle: write a to mem[idx]; count <= idx+1; then a <= b, b <= a+b, computed at DATA_W+1 bits.
- Overflow rule: if the (DATA_W+1)-bit sum has its MSB set, the term it would produce is not written. Set overflow=1 and go to DONE after the current write. Only terms representable in DATA_W are ever stored.
- Latency: first write on the cycle after start. With no overflow, the last write is start+n_eff cycles and done rises on the following cycle.
- n=0: GEN lasts one cycle with no write; DONE with count=0.
- n>DEPTH: clamped to DEPTH; no wrap-around and no address overwrite within a run.
- start while busy: ignored; n is not resampled.
- Reads:
  - rd_req at cycle t gives rd_valid at t+1.
  - If rd_addr < count at t: rd_data = mem[rd_addr], rd_err=0.
  - Otherwise rd_data=0, rd_err=1.
  - Reads during GEN are legal. An address written in the same cycle is not yet counted and returns rd_err=1, so there is no read/write collision.
- Reset mid-run: abandons generation and returns to IDLE next cycle; a pending read is dropped (rd_valid=0).
- A new start clears count at once, so earlier terms are immediately unreadable.

Optional Feature:
FIB_SEQ_CHECKSUM_EN: adds output checksum [DATA_W-1:0], the running sum modulo 2^DATA_W of every term written this run. It is cleared on rst and on an accepted start, and is stable in DONE. Without the macro the port and adder are absent and behaviour is otherwise identical.

Decomposition:
- Package fib_seq_pkg: state enum (IDLE, GEN, DONE); default DATA_W/DEPTH localparams; helper function clamp_n.
- Sub-module fib_seq_ram: one synchronous write port and one registered read port, parametrised on DATA_W and DEPTH.
- FSM, operand registers and read-error logic stay in fib_seq_buffer.

Test Plan:
- Defaults, n=10, start -> 10 write cycles, done at start+11, count=10. Reading addresses 0..9 returns 0,1,1,2,3,5,8,13,21,34 with rd_err=0; addr 10 -> rd_data=0, rd_err=1. With FIB_SEQ_CHECKSUM_EN, checksum=88.
- DATA_W=8, n=20 -> overflow=1, count=14, addr 13 reads 233, addr 14 gives rd_err=1.
- n=0 -> done after 2 cycles, count=0, any read gives rd_err=1. n=100 with DEPTH=64 -> count=64, addr 63 reads F(63) (DATA_W=64 build).
- Start pulsed during GEN -> ignored, run completes with the original n. Start in DONE with n=3 -> count restarts at 0 and finishes at 3.
- rst asserted at GEN cycle 5 -> IDLE next cycle, count=0, done=0. A read the cycle after reset gives rd_valid=1, rd_err=1.
- Read addr 4 issued during GEN while count=3 -> rd_err=1. Same read after count=5 -> rd_data=3.
